// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : uart_pkg                                           |
// | Description : Constants and types shared by UART TX-side blocks. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int c_byte_w = 8;
    localparam int c_depth  = 16;
    localparam int c_aw     = 4;

    typedef logic [c_byte_w-1:0] uart_byte_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : uart_fifo_ram                                      |
// | Description : DEPTH x byte storage, synchronous write, async read|
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  uart_byte_t    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output uart_byte_t    o_rd_data
);

    // Contents are intentionally left unreset; occupancy lives in the controller.
    uart_byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : uart_fifo_ram
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : uart_tx_buffer                                     |
// | Description : FWFT byte buffer feeding the UART transmitter.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [AW:0]   c_full_level = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_level_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_ovf;

    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    uart_byte_t    w_rd_data;

    assign full     = (r_level == c_full_level);
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign ovf      = r_ovf;
    assign tx_valid = !empty;
    assign tx_data  = w_rd_data;

    // Fullness is judged on the registered level, so a same-cycle pop cannot rescue a push.
    assign w_push = wr_en && !full;
    assign w_drop = wr_en && full;
    assign w_pop  = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_level_one;
                2'b01:   r_level <= r_level - c_level_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop wins over a coincident clear; flush leaves the flag alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_push && !flush),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule : uart_tx_buffer
`default_nettype wire

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port clk, input, 1, single clock domain for the whole block.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port wr_en, input, 1, bus-side push request for one byte.
REQ-006 Port wr_data, input, 8, byte to push.
REQ-007 Port flush, input, 1, synchronous discard of all buffered bytes.
REQ-008 Port clr_ovf, input, 1, clears the sticky overflow flag.
REQ-009 Port tx_valid, output, 1, head byte available to the transmitter.
REQ-010 Port tx_data, output, 8, head byte; LSB is sent first downstream.
REQ-011 Port tx_ready, input, 1, transmitter accepts tx_data this cycle.
REQ-012 Port full, output, 1, level equals DEPTH.
REQ-013 Port empty, output, 1, level equals 0.
REQ-014 Port level, output, AW+1, number of buffered bytes.
REQ-015 Port ovf, output, 1, sticky flag: a push was dropped.

Function
REQ-016 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter, all registered.
REQ-017 Push SHALL occur on a rising clk edge when wr_en=1 and full=0 (full as registered before the edge); wr_data SHALL be written at the write pointer, and the write pointer SHALL advance.
REQ-018 Pop SHALL occur on a rising clk edge when tx_valid=1 and tx_ready=1; the read pointer SHALL advance.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated byte.
REQ-020 Mode is first-word-fall-through: tx_valid=!empty and tx_data=entry at the read pointer, both from registered state only, with no combinational path from any input.
REQ-021 Latency: a byte pushed at edge N SHALL be presented on tx_valid/tx_data in the cycle after edge N when the buffer was empty.
REQ-022 tx_data SHALL hold stable while tx_valid=1 and no pop occurs.
REQ-023 Push with pop in the same cycle SHALL leave level unchanged; push alone adds 1; pop alone subtracts 1.
REQ-024 When full, wr_en=1 SHALL drop the byte and set ovf, even if a pop occurs in the same cycle.
REQ-025 When empty, no pop SHALL occur regardless of tx_ready; tx_data is don't-care.
REQ-026 ovf SHALL stay set until a cycle with clr_ovf=1; if a drop and clr_ovf coincide, ovf SHALL stay 1.
REQ-027 flush=1 SHALL zero both pointers and level at the edge and SHALL override any push or pop in that cycle.
REQ-028 flush SHALL not affect ovf.
REQ-029 full, empty and level SHALL be consistent with the occupancy counter in every cycle.

Reset
REQ-030 rst=1 SHALL asynchronously force pointers=0 and level=0, giving tx_valid=0, empty=1, full=0 and ovf=0.
REQ-031 Storage array contents SHALL not be reset.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered bytes; no pop is counted for a byte presented in the reset cycle.
REQ-033 After rst is deasserted, the first push SHALL be accepted at the next rising edge.

Structure
REQ-034 The byte width (8) and default depth SHALL be constants in shared package uart_pkg, used by both the transmitter and this block.
REQ-035 The storage array SHALL be one sub-module, uart_fifo_ram: synchronous write, asynchronous read, DEPTH x 8, no reset.
REQ-036 Pointer, counter, flag and handshake logic SHALL live in uart_tx_buffer.

Verification
REQ-037 Push 0x55, 0xA3 with tx_ready=0 -> level=2, tx_valid=1, tx_data=0x55; then tx_ready=1 for two cycles -> 0x55 then 0xA3 popped, empty=1.
REQ-038 Push 16 bytes 0x00..0x0F, then push 0xFF -> full=1, ovf=1, 0xFF is dropped; drain -> output is 0x00..0x0F in order.
REQ-039 Hold level at 8, then run push and pop every cycle for 40 cycles (pointers wrap) -> level stays 8 and the output sequence equals the input sequence.
REQ-040 With full=1, wr_en=1, tx_ready=1 and clr_ovf=1 in the same cycle -> one pop, push dropped, level=15, ovf=1.
REQ-041 Level 5 with flush=1 and wr_en=1 in the same cycle -> level=0 and empty=1 next cycle, ovf unchanged.
REQ-042 Assert rst asynchronously mid-cycle at level 3 -> tx_valid=0 and level=0 immediately; after release, push 0x7E -> tx_data=0x7E in the next cycle.
